vga_fb_ram: RTL and testbench

Parametrised framebuffer memory for the VGA driver. It is the next generation of the 2k x 8 framebuffer.
- Configurable data width and depth.
- Port 1: one read/write port for the MCU side.
- Port 2: one read-only port for the VGA scan side.
- Built-in fill engine that clears or fills the whole buffer one word per clock, replacing the single-cycle whole-array reset.
- Sits between the MCU I/O bus and the VGA scan/pixel generator.

---
 rtl/vga_fb_ram.sv | 124 ++++++++++++
 tb/tb_vga_fb_ram.sv | 131 +++++++++++++
 2 files changed

// File: rtl/vga_fb_ram.sv
// Dual-port framebuffer (MCU read/write, VGA read-only) with a word-per-clock fill engine.
// Optional macro VGA_FB_READ_REG_EN registers both read ports (read-first, one-cycle latency).
module vga_fb_ram #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 11,
  parameter int                DEPTH    = 2048,
  parameter logic [DATA_W-1:0] FILL_VAL = '1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA1,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] RD2,
  input  logic              CLR,
  input  logic [DATA_W-1:0] CLR_DATA,
  output logic              BUSY,
  output logic              DONE
);

  localparam int                IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cnt, cnt_nx;
  logic [DATA_W-1:0]   fill_val, fill_nx;
  logic                done, done_nx;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_wa;
  logic [DATA_W-1:0]   mem_wd;
  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  // Range check is done one bit wider so DEPTH == 2**ADDR_W works too.
  function automatic logic in_rng(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(DEPTH));
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= FILL;
      cnt      <= '0;
      fill_val <= FILL_VAL;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      fill_val <= fill_nx;
      done     <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fill_nx  = fill_val;
    done_nx  = 1'b0;
    mem_we   = 1'b0;
    mem_wa   = WA1[IDX_W-1:0];
    mem_wd   = WD;
    case (state)
      IDLE: begin
        if (CLR) begin
          fill_nx  = CLR_DATA;
          cnt_nx   = '0;
          state_nx = FILL;
        end else if (WE && in_rng(WA1)) begin
          mem_we = 1'b1;
        end
      end
      FILL: begin
        // A new request restarts the sweep; the aborted fill never signals DONE.
        if (CLR) begin
          fill_nx = CLR_DATA;
          cnt_nx  = '0;
        end else begin
          mem_we = 1'b1;
          mem_wa = cnt[IDX_W-1:0];
          mem_wd = fill_val;
          if (cnt == LAST) begin
            cnt_nx   = '0;
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Writes are blocked while reset is held so memory keeps its contents.
  always_ff @(posedge CLK) begin
    if (mem_we && RST_N) mem[mem_wa] <= mem_wd;
  end

  assign BUSY = (state == FILL);
  assign DONE = done;

`ifdef VGA_FB_READ_REG_EN
  logic [DATA_W-1:0] rd1_q, rd2_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= in_rng(WA1) ? mem[WA1[IDX_W-1:0]] : '0;
      rd2_q <= in_rng(RA2) ? mem[RA2[IDX_W-1:0]] : '0;
    end
  end

  assign RD1 = rd1_q;
  assign RD2 = rd2_q;
`else
  assign RD1 = in_rng(WA1) ? mem[WA1[IDX_W-1:0]] : '0;
  assign RD2 = in_rng(RA2) ? mem[RA2[IDX_W-1:0]] : '0;
`endif

endmodule

// File: tb/tb_vga_fb_ram.sv
// Directed bench for vga_fb_ram with DEPTH=16, ADDR_W=5: fill timing, writes, CLR races, range, reset.
module tb_vga_fb_ram;
  logic       CLK, RST_N, WE, CLR, BUSY, DONE;
  logic [4:0] WA1, RA2;
  logic [7:0] WD, RD1, RD2, CLR_DATA;
  int         n_chk, n_err, n;

  vga_fb_ram #(.DATA_W(8), .ADDR_W(5), .DEPTH(16), .FILL_VAL(8'hFF)) dut (
    .CLK(CLK), .RST_N(RST_N), .WE(WE), .WA1(WA1), .WD(WD), .RD1(RD1),
    .RA2(RA2), .RD2(RD2), .CLR(CLR), .CLR_DATA(CLR_DATA), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts edges until DONE is seen (bounded); result 100 means it never came.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (cnt < 100) begin
      @(posedge CLK); #1;
      cnt++;
      if (DONE) break;
    end
  endtask

  // Present an address on both ports; sampled one edge later works for both read builds.
  task automatic rd(input logic [4:0] a);
    WA1 = a; RA2 = a;
    @(posedge CLK); #1;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    CLK = 0; RST_N = 0; WE = 0; CLR = 0; WA1 = 0; RA2 = 0; WD = 0; CLR_DATA = 0;

    repeat (2) @(posedge CLK); #1;
    chk("rst_busy", BUSY, 1);
    chk("rst_done", DONE, 0);
`ifdef VGA_FB_READ_REG_EN
    chk("rst_rd1", RD1, 0);
    chk("rst_rd2", RD2, 0);
`endif

    // Power-up fill
    RST_N = 1;
    wait_done(n);
    chk("init_fill_len", n, 16);
    chk("init_busy_end", BUSY, 0);
    @(posedge CLK); #1;
    chk("done_one_cycle", DONE, 0);
    for (int i = 0; i < 16; i++) begin
      rd(5'(i));
      chk($sformatf("init_rd2_%0d", i), RD2, 8'hFF);
    end

    // Plain write then readback on both ports
    WE = 1; WA1 = 5; WD = 8'h3C;
    @(posedge CLK); #1;
    WE = 0;
    rd(5);
    chk("wr5_rd1", RD1, 8'h3C);
    chk("wr5_rd2", RD2, 8'h3C);

    // CLR beats a simultaneous write; writes held during the fill are ignored
    CLR = 1; CLR_DATA = 8'h00; WE = 1; WA1 = 2; WD = 8'hAA;
    @(posedge CLK); #1;
    CLR = 0;
    chk("clr_busy", BUSY, 1);
    WA1 = 3; WD = 8'h77;
    wait_done(n);
    WE = 0;
    chk("clr_fill_len", n, 16);
    rd(2);
    chk("clr_beats_we", RD2, 8'h00);
    rd(3);
    chk("we_in_fill", RD1, 8'h00);
    rd(5);
    chk("clr_addr5", RD2, 8'h00);

    // Restart mid-fill at counter=8
    CLR = 1; CLR_DATA = 8'hA5;
    @(posedge CLK); #1;
    CLR = 0;
    repeat (8) @(posedge CLK); #1;
    chk("mid_no_done", DONE, 0);
    CLR = 1; CLR_DATA = 8'h55;
    @(posedge CLK); #1;
    CLR = 0;
    wait_done(n);
    chk("restart_len", n, 16);
    rd(0);  chk("restart_a0", RD2, 8'h55);
    rd(8);  chk("restart_a8", RD2, 8'h55);
    rd(15); chk("restart_a15", RD2, 8'h55);

    // Out-of-range write must not alias onto address 4
    WE = 1; WA1 = 20; WD = 8'h11;
    @(posedge CLK); #1;
    WE = 0;
    rd(4);  chk("oor_no_alias", RD1, 8'h55);
    rd(20); chk("oor_rd1", RD1, 8'h00);
    RA2 = 31; WA1 = 0;
    @(posedge CLK); #1;
    chk("oor_rd2", RD2, 8'h00);

    // Reset in the middle of a fill
    CLR = 1; CLR_DATA = 8'h33;
    @(posedge CLK); #1;
    CLR = 0;
    repeat (5) @(posedge CLK); #1;
    RST_N = 0;
    #1;
    chk("midrst_busy", BUSY, 1);
    chk("midrst_done", DONE, 0);
    @(posedge CLK); #1;
    RST_N = 1;
    wait_done(n);
    chk("midrst_fill_len", n, 16);
    rd(2);  chk("midrst_a2", RD2, 8'hFF);
    rd(10); chk("midrst_a10", RD2, 8'hFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
